// File: rtl/abc_pkg.sv
// Shared types and constants for the ABC coincidence-counter stimulus source.
package abc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FIRE1,
        S_LAG,
        S_FIRE2,
        S_RANDOM,
        S_DONE
    } state_e;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_CORR = 2'b01;
    localparam logic [1:0] MODE_RAND = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Taps 16,14,13,11 as a bit mask over q[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

endpackage

// File: rtl/abc_lfsr.sv
// Fibonacci LFSR, shifts left, feedback is the XOR of the tapped bits.
module abc_lfsr
    import abc_pkg::*;
#(
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = DEF_SEED[LFSR_W-1:0],
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_TAPS[LFSR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    assign q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
    assign q   = q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else if (step) begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/abc_pulse_gen.sv
// Two-channel pulse source (correlated or LFSR-random) that also predicts
// the coincidence count the ABC counter should report.
module abc_pulse_gen
    import abc_pkg::*;
#(
    parameter int              CW     = 4,
    parameter int              WINDOW = 0,
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = DEF_SEED[LFSR_W-1:0]
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] n_events,
    output logic          X1,
    output logic          X2,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] coinc_exp
);

    state_e        state_q;
    logic [CW-1:0] period_q;
    logic [CW-1:0] delay_q;
    logic [CW-1:0] rem_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] coinc_q;
    logic [CW-1:0] coinc_d;
    logic          x1_q;
    logic          x2_q;
    logic          busy_q;
    logic          done_q;

    logic [LFSR_W-1:0] lfsr_q;
    logic [CW-1:0]     nib1;
    logic [CW-1:0]     nib2;
    logic              ev_end;
    logic              last_ev;
    logic              win_hit;
    logic              go;
    logic              unused_lfsr;

    abc_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (enable),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[LFSR_W-1:8];
    assign nib1        = CW'(lfsr_q[7:4]);
    assign nib2        = CW'(lfsr_q[3:0]);

    assign coinc_d = (coinc_q == '1) ? coinc_q : coinc_q + CW'(1);
    assign win_hit = (delay_q <= CW'(WINDOW));
    // rem_q == 0 encodes 2^CW, so only 1 marks the final event
    assign last_ev = (rem_q == CW'(1));
    assign ev_end  = (state_q == S_FIRE2) ||
                     ((state_q == S_FIRE1) && (delay_q == '0));
    assign go      = start && !stop &&
                     ((mode == MODE_CORR) || (mode == MODE_RAND));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            delay_q  <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            coinc_q  <= '0;
            x1_q     <= 1'b0;
            x2_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (enable) begin
            x1_q   <= 1'b0;
            x2_q   <= 1'b0;
            done_q <= 1'b0;
            if (stop && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (go) begin
                            period_q <= period;
                            delay_q  <= delay;
                            rem_q    <= n_events;
                            cnt_q    <= period;
                            coinc_q  <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= (mode == MODE_CORR) ? S_WAIT : S_RANDOM;
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == '0) begin
                            state_q <= S_FIRE1;
                            x1_q    <= 1'b1;
                            x2_q    <= (delay_q == '0);
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_FIRE1: begin
                        if (delay_q == CW'(1)) begin
                            state_q <= S_FIRE2;
                            x2_q    <= 1'b1;
                        end else if (delay_q != '0) begin
                            state_q <= S_LAG;
                            cnt_q   <= delay_q - CW'(2);
                        end
                    end
                    S_LAG: begin
                        if (cnt_q == '0) begin
                            state_q <= S_FIRE2;
                            x2_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                    S_FIRE2: begin
                    end
                    S_RANDOM: begin
                        if (x1_q) begin
                            rem_q <= rem_q - CW'(1);
                            if (x2_q) coinc_q <= coinc_d;
                        end
                        if (x1_q && last_ev) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            x1_q <= (nib1 < period_q);
                            x2_q <= (nib2 < period_q);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
                // Correlated event completes on its X2 cycle
                if (ev_end) begin
                    rem_q <= rem_q - CW'(1);
                    if (win_hit) coinc_q <= coinc_d;
                    if (last_ev) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= period_q;
                    end
                end
            end
        end
    end

    assign X1        = x1_q & enable;
    assign X2        = x2_q & enable;
    assign busy      = busy_q;
    assign done      = done_q;
    assign coinc_exp = coinc_q;

endmodule

// File: tb/tb_abc_pulse_gen.sv
// Directed bench for abc_pulse_gen: correlated, random, stop, enable, reset.
module tb_abc_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] period = '0;
    logic [3:0] delay = '0;
    logic [3:0] n_events = '0;
    logic       X1, X2, busy, done;
    logic [3:0] coinc_exp;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    logic [15:0] x1v, x2v, bv, dv;

    abc_pulse_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .delay     (delay),
        .n_events  (n_events),
        .X1        (X1),
        .X2        (X2),
        .busy      (busy),
        .done      (done),
        .coinc_exp (coinc_exp)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else if (enable) lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle c=0 is the start cycle; bit c-1 of each vector holds cycle c.
    task automatic run(input logic [1:0] m, input logic [3:0] p,
                       input logic [3:0] d, input logic [3:0] n,
                       input int stop_c, input int lo_a, input int lo_b,
                       output logic [15:0] v1, output logic [15:0] v2,
                       output logic [15:0] vb, output logic [15:0] vd);
        v1 = '0; v2 = '0; vb = '0; vd = '0;
        mode = m; period = p; delay = d; n_events = n;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            if (c > 0) begin
                v1[c-1] = X1;
                v2[c-1] = X2;
                vb[c-1] = busy;
                vd[c-1] = done;
            end
            start  = (c == 0);
            stop   = (c == stop_c);
            enable = !(c >= lo_a && c <= lo_b);
        end
    endtask

    initial begin
        int pulses;
        int cnt_co;
        logic e1, e2;

        #1;
        chk("rst_x1", X1, 0);
        chk("rst_x2", X2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coinc", coinc_exp, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        run(2'b01, 4'd2, 4'd0, 4'd3, -1, -1, -1, x1v, x2v, bv, dv);
        chk("t1_x1", x1v, 16'h0888);
        chk("t1_x2", x2v, 16'h0888);
        chk("t1_busy", bv, 16'h0FFF);
        chk("t1_done", dv, 16'h1000);
        chk("t1_coinc", coinc_exp, 3);
        chk("t3_cntA", $countones(x1v), 3);
        chk("t3_cntB", $countones(x2v), 3);
        chk("t3_cntAB", $countones(x1v & x2v), 3);

        run(2'b01, 4'd1, 4'd3, 4'd2, -1, -1, -1, x1v, x2v, bv, dv);
        chk("t2_x1", x1v, 16'h0104);
        chk("t2_x2", x2v, 16'h0820);
        chk("t2_busy", bv, 16'h0FFF);
        chk("t2_done", dv, 16'h1000);
        chk("t2_coinc", coinc_exp, 0);

        run(2'b11, 4'd2, 4'd0, 4'd3, -1, -1, -1, x1v, x2v, bv, dv);
        chk("rsvd_busy", bv, 16'h0000);
        chk("rsvd_x1", x1v, 16'h0000);

        run(2'b01, 4'd2, 4'd0, 4'd3, 5, -1, -1, x1v, x2v, bv, dv);
        chk("t5_x1", x1v, 16'h0008);
        chk("t5_x2", x2v, 16'h0008);
        chk("t5_busy", bv, 16'h001F);
        chk("t5_done", dv, 16'h0000);
        chk("t5_coinc", coinc_exp, 1);

        mode = 2'b10; period = 4'd8; n_events = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e1 = 1'b0; e2 = 1'b0;
        pulses = 0; cnt_co = 0;
        for (int k = 0; k < 400 && pulses < 16; k++) begin
            chk("rnd_x1", X1, e1);
            chk("rnd_x2", X2, e2);
            if (e1) pulses++;
            if (e1 && e2) cnt_co++;
            if (pulses < 16) begin
                e1 = (lfsr_m[7:4] < 4'd8);
                e2 = (lfsr_m[3:0] < 4'd8);
            end else begin
                e1 = 1'b0; e2 = 1'b0;
            end
            @(negedge clk);
        end
        chk("rnd_pulses", pulses, 16);
        chk("rnd_done", done, 1);
        chk("rnd_busy", busy, 0);
        chk("rnd_x1_end", X1, 0);
        chk("rnd_coinc", coinc_exp, cnt_co);
        @(negedge clk);

        run(2'b01, 4'd2, 4'd0, 4'd3, -1, 2, 6, x1v, x2v, bv, dv);
        chk("t6_x1", x1v, 16'h1100);
        chk("t6_x2", x2v, 16'h1100);
        chk("t6_busy", bv, 16'hFFFF);
        chk("t6_done", dv, 16'h0000);
        chk("t6_coinc_pre", coinc_exp, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_x1", X1, 0);
        chk("t6_rst_coinc", coinc_exp, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(2'b01, 4'd2, 4'd0, 4'd3, -1, -1, -1, x1v, x2v, bv, dv);
        chk("t6r_x1", x1v, 16'h0888);
        chk("t6r_x2", x2v, 16'h0888);
        chk("t6r_busy", bv, 16'h0FFF);
        chk("t6r_done", dv, 16'h1000);
        chk("t6r_coinc", coinc_exp, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
